// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared types and constants for the CNN convolution blocks.
//   N          : window / kernel edge length
//   FRAC_BITS  : fractional bits of the Q8.8 kernel weights
//   pixel_t    : 16-bit signed sample
//   window_t   : N x N array of pixel_t, row-major as [row][col]
//   acc_t      : 40-bit signed accumulator
//   state_t    : convolution FSM states
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int N         = 5;
    localparam int FRAC_BITS = 8;
    localparam int PIX_W     = 16;
    localparam int ACC_W     = 40;

    typedef logic signed [PIX_W-1:0] pixel_t;
    typedef pixel_t [N-1:0][N-1:0]   window_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv_mac_unit.sv
// ---------------------------------------------------------------------------
// conv_mac_unit
// Signed multiply-accumulate: 16x16 -> 32-bit product into a 40-bit acc.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears the acc)
//   clr      : synchronous clear of the accumulator (wins over en)
//   en       : add a_in*b_in into the accumulator on this edge
//   a_in     : pixel operand (signed)
//   b_in     : Q8.8 weight operand (signed)
//   acc      : running sum including the pair currently on a_in/b_in, so
//              the caller can capture the full total on the same edge that
//              consumes the last pair
// ---------------------------------------------------------------------------
module conv_mac_unit
    import cnn_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clr,
    input  logic   en,
    input  pixel_t a_in,
    input  pixel_t b_in,
    output acc_t   acc
);

    logic signed [31:0] prod;
    acc_t               acc_d;
    acc_t               acc_q;

    always_comb begin
        prod  = 32'(a_in) * 32'(b_in);
        acc   = acc_q + ACC_W'(prod);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/conv_5x5_mac.sv
// ---------------------------------------------------------------------------
// conv_5x5_mac
// Sequential N x N convolution: one multiply-accumulate per clock, result
// scaled from Q8.8, saturated to 16 bits and handed to the pooling stage.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : level request, sampled only in IDLE
//   window_in  : N x N signed image window, row-major
//   kernel_in  : N x N signed Q8.8 kernel weights
//   pixel_out  : saturated convolution result (held until the next job)
//   finish     : high while pixel_out holds a fresh result (DONE state)
//   busy       : high while the MAC loop is running
// Build option:
//   CONV_RELU_EN : when defined, negative results are clamped to 0.
// Timing: start sampled at E0, products idx 0..N*N-1 consumed on E1..E(N*N),
// finish rises on E(N*N).
// ---------------------------------------------------------------------------
module conv_5x5_mac
    import cnn_pkg::*;
#(
    parameter int N         = cnn_pkg::N,        // must match cnn_pkg::N (port types)
    parameter int FRAC_BITS = cnn_pkg::FRAC_BITS
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  window_t window_in,
    input  window_t kernel_in,
    output pixel_t  pixel_out,
    output logic    finish,
    output logic    busy
);

    localparam int               IDX_W    = $clog2(N * N);
    localparam int               RC_W     = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);
    localparam acc_t             SAT_MAX  = 40'sd32767;
    localparam acc_t             SAT_MIN  = -40'sd32768;

    // Scale the Q8.8 sum back to integer and clip into 16 bits.
    function automatic pixel_t saturate(input acc_t v);
        acc_t s;
        s = v >>> FRAC_BITS;
        if (s > SAT_MAX) begin
            return pixel_t'(SAT_MAX[PIX_W-1:0]);
        end else if (s < SAT_MIN) begin
            return pixel_t'(SAT_MIN[PIX_W-1:0]);
        end
        return pixel_t'(s[PIX_W-1:0]);
    endfunction

`ifdef CONV_RELU_EN
    function automatic pixel_t relu(input pixel_t v);
        return v[PIX_W-1] ? '0 : v;
    endfunction
`endif

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             finish_q, finish_d;
    pixel_t           pixel_q, pixel_d;
    window_t          window_q, window_d;
    window_t          kernel_q, kernel_d;

    logic [RC_W-1:0]  row, col;
    pixel_t           op_a, op_b;
    logic             mac_clr, mac_en;
    acc_t             mac_acc;
    pixel_t           result;

    // Operand select from the captured window/kernel.
    always_comb begin
        row  = RC_W'(idx_q / IDX_W'(N));
        col  = RC_W'(idx_q % IDX_W'(N));
        op_a = window_q[row][col];
        op_b = kernel_q[row][col];
    end

    conv_mac_unit u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (mac_clr),
        .en   (mac_en),
        .a_in (op_a),
        .b_in (op_b),
        .acc  (mac_acc)
    );

    // Post-processing of the final sum.
    always_comb begin
`ifdef CONV_RELU_EN
        result = relu(saturate(mac_acc));
`else
        result = saturate(mac_acc);
`endif
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        finish_d = finish_q;
        pixel_d  = pixel_q;
        window_d = window_q;
        kernel_d = kernel_q;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    window_d = window_in;
                    kernel_d = kernel_in;
                    mac_clr  = 1'b1;
                    idx_d    = '0;
                    state_d  = MAC;
                end
            end
            MAC: begin
                // start is deliberately ignored here: a job always completes.
                mac_en = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    pixel_d  = result;
                    finish_d = 1'b1;
                    idx_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // Holding start keeps the result presented; a new job needs
                // start low for one edge so we pass back through IDLE.
                if (!start) begin
                    finish_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                finish_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            finish_q <= 1'b0;
            pixel_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            finish_q <= finish_d;
            pixel_q  <= pixel_d;
        end
    end

    // Operand capture needs no reset: it is only read after a start load.
    always_ff @(posedge clk) begin
        window_q <= window_d;
        kernel_q <= kernel_d;
    end

    assign pixel_out = pixel_q;
    assign finish    = finish_q;
    assign busy      = (state_q == MAC);

endmodule

// File: tb/tb_conv_5x5_mac.sv
// ---------------------------------------------------------------------------
// tb_conv_5x5_mac
// Directed checks of conv_5x5_mac. Edge counts include the start-sampling
// edge E0, so a result appearing on E25 is counted as 26 edges.
// ---------------------------------------------------------------------------
module tb_conv_5x5_mac;
    import cnn_pkg::*;

    logic    clk;
    logic    rst;
    logic    start;
    window_t window_in;
    window_t kernel_in;
    pixel_t  pixel_out;
    logic    finish;
    logic    busy;

    int n_cmp  = 0;
    int n_fail = 0;

    conv_5x5_mac #(.N(5), .FRAC_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .window_in (window_in),
        .kernel_in (kernel_in),
        .pixel_out (pixel_out),
        .finish    (finish),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_all(output window_t w, input pixel_t v);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[r][c] = v;
    endtask

    // Raise start (state must be IDLE) and count edges until finish, bounded.
    task automatic run_job(input window_t w, input window_t k, output int edges);
        window_in = w;
        kernel_in = k;
        start     = 1'b1;
        edges     = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!finish && edges < 60);
    endtask

    task automatic drop_start();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        set_all(window_in, 16'sd0);
        set_all(kernel_in, 16'sd0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pixel_out !== 16'sd0) begin n_fail++; $display("FAIL reset_pixel: got %0d want 0", pixel_out); end
        n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b want 0", finish); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        window_t w, k;
        int      edges;
        logic    busy_after_e0;
        logic    overlap;
        set_all(w, 16'sd4);
        set_all(k, 16'sh0100);
        window_in     = w;
        kernel_in     = k;
        start         = 1'b1;
        edges         = 0;
        overlap       = 1'b0;
        busy_after_e0 = 1'b0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) busy_after_e0 = busy;
            if (busy && finish) overlap = 1'b1;
        end while (!finish && edges < 60);
        n_cmp++; if (busy_after_e0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mac: got %b want 1", busy_after_e0); end
        n_cmp++; if (edges != 26) begin n_fail++; $display("FAIL basic_latency: got %0d edges want 26", edges); end
        n_cmp++; if (pixel_out !== 16'sd100) begin n_fail++; $display("FAIL basic_pixel: got %0d want 100", pixel_out); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b want 0", busy); end
        n_cmp++; if (overlap !== 1'b0) begin n_fail++; $display("FAIL basic_busy_finish_overlap: got %b want 0", overlap); end
        // start still held: result must stay presented
        set_all(window_in, 16'sd50);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (finish !== 1'b1) begin n_fail++; $display("FAIL hold_finish: got %b want 1", finish); end
        n_cmp++; if (pixel_out !== 16'sd100) begin n_fail++; $display("FAIL hold_pixel: got %0d want 100", pixel_out); end
        drop_start();
        n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL release_finish: got %b want 0", finish); end
        n_cmp++; if (pixel_out !== 16'sd100) begin n_fail++; $display("FAIL release_pixel: got %0d want 100", pixel_out); end
    endtask

    task automatic test_saturation();
        window_t w, k;
        int      edges;
        pixel_t  exp_neg;
        set_all(k, 16'sh7FFF);
        set_all(w, 16'sd1000);
        run_job(w, k, edges);
        n_cmp++; if (edges != 26) begin n_fail++; $display("FAIL sat_pos_latency: got %0d want 26", edges); end
        n_cmp++; if (pixel_out !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos_pixel: got %0d want 32767", pixel_out); end
        drop_start();
        set_all(w, -16'sd1000);
        run_job(w, k, edges);
`ifdef CONV_RELU_EN
        exp_neg = pixel_t'(0);
`else
        exp_neg = pixel_t'(-32768);
`endif
        n_cmp++; if (edges != 26) begin n_fail++; $display("FAIL sat_neg_latency: got %0d want 26", edges); end
        n_cmp++; if (pixel_out !== exp_neg) begin n_fail++; $display("FAIL sat_neg_pixel: got %0d want %0d", pixel_out, exp_neg); end
        drop_start();
    endtask

    task automatic test_identity();
        window_t w, k;
        int      edges;
        pixel_t  exp_px;
        set_all(k, 16'sd0);
        k[2][2] = 16'sh0100;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                w[r][c] = pixel_t'(r * 10 + c + 1);
        w[2][2] = -16'sd7;
        run_job(w, k, edges);
`ifdef CONV_RELU_EN
        exp_px = pixel_t'(0);
`else
        exp_px = pixel_t'(-7);
`endif
        n_cmp++; if (pixel_out !== exp_px) begin n_fail++; $display("FAIL identity_pixel: got %0d want %0d", pixel_out, exp_px); end
        drop_start();
    endtask

    task automatic test_input_change();
        window_t w, k;
        int      edges;
        set_all(w, 16'sd4);
        set_all(k, 16'sh0100);
        window_in = w;
        kernel_in = k;
        start     = 1'b1;
        edges     = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 11) begin   // just after E10
                set_all(window_in, 16'sd9);
                set_all(kernel_in, 16'sh0200);
                start = 1'b0;
            end
        end while (!finish && edges < 60);
        n_cmp++; if (edges != 26) begin n_fail++; $display("FAIL change_latency: got %0d want 26", edges); end
        n_cmp++; if (pixel_out !== 16'sd100) begin n_fail++; $display("FAIL change_pixel: got %0d want 100", pixel_out); end
        @(posedge clk); #1;
        n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL change_finish_clear: got %b want 0", finish); end
    endtask

    task automatic test_reset_abort();
        window_t w, k;
        logic    seen;
        set_all(w, 16'sd4);
        set_all(k, 16'sh0100);
        window_in = w;
        kernel_in = k;
        start     = 1'b1;
        repeat (13) @(posedge clk);  // E0..E12
        #1;
        start = 1'b0;
        rst   = 1'b1;
        #1;
        n_cmp++; if (pixel_out !== 16'sd0) begin n_fail++; $display("FAIL abort_pixel: got %0d want 0", pixel_out); end
        n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL abort_finish: got %b want 0", finish); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (finish) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_finish: got %b want 0", seen); end
    endtask

    task automatic test_random();
        window_t w, k;
        int      edges;
        int      sum;
        set_all(k, 16'sh0100);
        for (int j = 0; j < 300; j++) begin
            sum = 0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    w[r][c] = pixel_t'($urandom_range(0, 99));
                    sum += int'(w[r][c]);
                end
            run_job(w, k, edges);
            n_cmp++; if (edges != 26) begin n_fail++; $display("FAIL rand_latency job %0d: got %0d want 26", j, edges); end
            n_cmp++; if (pixel_out !== pixel_t'(sum)) begin n_fail++; $display("FAIL rand_pixel job %0d: got %0d want %0d", j, pixel_out, sum); end
            drop_start();
            n_cmp++; if (finish !== 1'b0) begin n_fail++; $display("FAIL rand_finish_clear job %0d: got %b want 0", j, finish); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_identity();
        test_input_change();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
